// File: rtl/window_3x3_stream_module_if.sv
// Raster pixel stream into, and 3x3 window stream out of, the window builder.
interface window_3x3_stream_module_if;
  logic [11:0]  pixel_in;
  logic         pixel_valid;
  logic         frame_start;
  logic         in_ready;
  logic [107:0] color_data;
  logic         window_valid;
  logic [9:0]   center_x;
  logic [8:0]   center_y;
  logic         frame_done;

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  in_ready, color_data, window_valid, center_x, center_y, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output in_ready, color_data, window_valid, center_x, center_y, frame_done
  );
endinterface

// File: rtl/window_3x3_stream_module.sv
// Raster RGB444 stream to zero-padded 3x3 neighbourhood words, one window per pixel,
// with a fixed lag of IMG_WIDTH+1 accepted pixels and a self-driven end-of-frame flush.
module window_3x3_stream_module #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  window_3x3_stream_module_if.slave bus
);

  localparam int unsigned PW = 12;
  localparam int unsigned WW = 9 * PW;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned AW = $clog2(IMG_WIDTH);
  localparam int unsigned FW = $clog2(IMG_WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]    state, next_state;
  logic [FW-1:0] fill_cnt, fill_cnt_c;
  logic [XW-1:0] cx, cx_c;
  logic [YW-1:0] cy, cy_c;
  logic [AW-1:0] wr_ptr;

  logic          xfer_c, advance_c, emit_c, done_c;
  logic [PW-1:0] din_c, lb1_rd_c, lb2_rd_c;
  logic          mask_l_c, mask_r_c, mask_u_c, mask_d_c;
  logic [WW-1:0] window_c;

  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] lb2 [IMG_WIDTH];
  logic [PW-1:0] bot0, bot1, mid0, mid1, top0, top1;

  logic          in_ready_q, window_valid_q, frame_done_q;
  logic [WW-1:0] color_q;
  logic [XW-1:0] center_x_q;
  logic [YW-1:0] center_y_q;

  function automatic logic [PW-1:0] tap(input logic [PW-1:0] px, input logic kill);
    return kill ? '0 : px;
  endfunction

  assign xfer_c   = bus.pixel_valid & in_ready_q;
  // Line buffers delay by exactly one and two lines relative to the incoming pixel.
  assign lb1_rd_c = lb1[wr_ptr];
  assign lb2_rd_c = lb2[wr_ptr];

  // Frame sequencing; cx/cy always name the centre of the next window to emit.
  always_comb begin
    next_state = state;
    fill_cnt_c = fill_cnt;
    cx_c       = cx;
    cy_c       = cy;
    advance_c  = 1'b0;
    emit_c     = 1'b0;
    done_c     = 1'b0;
    din_c      = bus.pixel_in;
    case (state)
      S_IDLE: begin
        if (xfer_c && bus.frame_start) begin
          advance_c  = 1'b1;
          fill_cnt_c = FW'(1);
          next_state = S_FILL;
        end
      end
      S_FILL: begin
        if (xfer_c) begin
          advance_c = 1'b1;
          if (bus.frame_start) begin
            fill_cnt_c = FW'(1);
          end else if (fill_cnt == FW'(IMG_WIDTH)) begin
            next_state = S_STREAM;
            cx_c       = '0;
            cy_c       = '0;
          end else begin
            fill_cnt_c = fill_cnt + FW'(1);
          end
        end
      end
      S_STREAM: begin
        if (xfer_c) begin
          advance_c = 1'b1;
          if (bus.frame_start) begin
            fill_cnt_c = FW'(1);
            next_state = S_FILL;
          end else begin
            emit_c = 1'b1;
            if (cx == XW'(IMG_WIDTH - 2) && cy == YW'(IMG_HEIGHT - 2)) next_state = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        advance_c = 1'b1;
        emit_c    = 1'b1;
        din_c     = '0;
        if (cx == XW'(IMG_WIDTH - 1) && cy == YW'(IMG_HEIGHT - 1)) begin
          done_c     = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (emit_c) begin
      if (cx == XW'(IMG_WIDTH - 1)) begin
        cx_c = '0;
        cy_c = cy + YW'(1);
      end else begin
        cx_c = cx + XW'(1);
      end
    end
  end

  // Window for the next centre from the pre-shift taps plus this cycle's column inputs.
  always_comb begin
    mask_l_c = (cx == '0);
    mask_r_c = (cx == XW'(IMG_WIDTH - 1));
    mask_u_c = (cy == '0);
    mask_d_c = (cy == YW'(IMG_HEIGHT - 1));
    window_c = {mid0,
                tap(mid1,     mask_l_c),
                tap(lb1_rd_c, mask_r_c),
                tap(top0,     mask_u_c),
                tap(bot0,     mask_d_c),
                tap(top1,     mask_u_c | mask_l_c),
                tap(lb2_rd_c, mask_u_c | mask_r_c),
                tap(bot1,     mask_d_c | mask_l_c),
                tap(din_c,    mask_d_c | mask_r_c)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      fill_cnt       <= '0;
      cx             <= '0;
      cy             <= '0;
      wr_ptr         <= '0;
      in_ready_q     <= 1'b1;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      color_q        <= '0;
      center_x_q     <= '0;
      center_y_q     <= '0;
    end else begin
      state          <= next_state;
      fill_cnt       <= fill_cnt_c;
      cx             <= cx_c;
      cy             <= cy_c;
      in_ready_q     <= (next_state != S_FLUSH);
      window_valid_q <= emit_c;
      frame_done_q   <= done_c;
      if (emit_c) begin
        color_q    <= window_c;
        center_x_q <= cx;
        center_y_q <= cy;
      end
      if (advance_c) wr_ptr <= (wr_ptr == AW'(IMG_WIDTH - 1)) ? '0 : wr_ptr + AW'(1);
    end
  end

  // Pixel storage needs no reset: fill and masking keep stale data out of the output.
  always_ff @(posedge clk) begin
    if (advance_c) begin
      lb1[wr_ptr] <= din_c;
      lb2[wr_ptr] <= lb1_rd_c;
      bot1        <= bot0;
      bot0        <= din_c;
      mid1        <= mid0;
      mid0        <= lb1_rd_c;
      top1        <= top0;
      top0        <= lb2_rd_c;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.color_data   = color_q;
  assign bus.window_valid = window_valid_q;
  assign bus.center_x     = center_x_q;
  assign bus.center_y     = center_y_q;
  assign bus.frame_done   = frame_done_q;

endmodule
